// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths and the pool_quant FSM state type.
package npu_pkg;

  localparam int CONV_DATA_W = 24;  // signed conv accumulator output
  localparam int ACT_W       = 8;   // unsigned quantised activation
  localparam int CHAN_W      = 4;   // channel index
  localparam int ROW_W       = 3;   // pooled row coordinate
  localparam int COL_W       = 3;   // pooled column coordinate

  typedef enum logic {
    PQ_IDLE = 1'b0,
    PQ_SCAN = 1'b1
  } pq_state_e;

endpackage

// File: rtl/pool_quant_if.sv
// Frame-in / pixel-out bus of pool_quant. The slave modport is the block,
// the master modport is whoever feeds frames and consumes pooled pixels.
interface pool_quant_if
  import npu_pkg::*;
#(
  parameter int IN_H = 12,
  parameter int IN_W = 11
);

  logic                          in_valid;
  logic signed [CONV_DATA_W-1:0] in_frame [IN_H][IN_W];
  logic [CHAN_W-1:0]             in_chan;
  logic                          in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACT_W-1:0]              out_data;
  logic [CHAN_W-1:0]             out_chan;
  logic [ROW_W-1:0]              out_row;
  logic [COL_W-1:0]              out_col;
  logic                          out_last;
  logic                          drop_err;

  modport master (
    output in_valid, in_frame, in_chan, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_row, out_col,
           out_last, drop_err
  );

  modport slave (
    input  in_valid, in_frame, in_chan, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_row, out_col,
           out_last, drop_err
  );

endinterface

// File: rtl/pool_quant_unit.sv
// One pooled pixel: signed max of a 2x2 window, ReLU, optional round-half-up
// (POOL_QUANT_ROUND_EN), right shift by SHIFT, saturate to 8 bits unsigned.
module pool_quant_unit
  import npu_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic signed [CONV_DATA_W-1:0] p00,
  input  logic signed [CONV_DATA_W-1:0] p01,
  input  logic signed [CONV_DATA_W-1:0] p10,
  input  logic signed [CONV_DATA_W-1:0] p11,
  output logic [ACT_W-1:0]              q
);

  // One spare bit so the rounding bias cannot wrap the largest positive value.
  localparam int SUM_W = CONV_DATA_W + 1;

  logic signed [CONV_DATA_W-1:0] max_top;
  logic signed [CONV_DATA_W-1:0] max_bot;
  logic signed [CONV_DATA_W-1:0] max_all;
  logic [SUM_W-1:0]              relu;
  logic [SUM_W-1:0]              biased;
  logic [SUM_W-1:0]              shifted;

  // max4 -> ReLU -> bias -> shift -> saturate, purely combinational
  always_comb begin
    max_top = (p01 > p00) ? p01 : p00;
    max_bot = (p11 > p10) ? p11 : p10;
    max_all = (max_bot > max_top) ? max_bot : max_top;
    relu    = max_all[CONV_DATA_W-1] ? '0 : {1'b0, max_all};
`ifdef POOL_QUANT_ROUND_EN
    biased  = relu + (SUM_W'(1) << (SHIFT - 1));
`else
    biased  = relu;
`endif
    shifted = biased >> SHIFT;
    q       = (shifted > SUM_W'(2**ACT_W - 1)) ? '1 : shifted[ACT_W-1:0];
  end

endmodule

// File: rtl/pool_quant.sv
// 2x2 max-pool + requantiser. Captures one channel's conv map while idle,
// then streams OUT_H*OUT_W pooled 8-bit pixels in row-major order under a
// valid/ready handshake. Build option: POOL_QUANT_ROUND_EN (round half up).
module pool_quant
  import npu_pkg::*;
#(
  parameter int IN_H  = 12,
  parameter int IN_W  = 11,
  parameter int SHIFT = 8
) (
  input logic         clk,
  input logic         rst,
  pool_quant_if.slave bus
);

  localparam int OUT_H  = IN_H / 2;
  localparam int OUT_W  = IN_W / 2;
  localparam int RIDX_W = $clog2(IN_H);
  localparam int CIDX_W = $clog2(IN_W);

  pq_state_e state;
  pq_state_e state_next;
  logic      capture;
  logic      final_hs;
  logic      load;

  logic signed [CONV_DATA_W-1:0] frame_buf [IN_H][IN_W];
  logic [CHAN_W-1:0]             chan_q;
  logic [ROW_W-1:0]              row_cnt;
  logic [COL_W-1:0]              col_cnt;
  logic [RIDX_W-1:0]             r0;
  logic [RIDX_W-1:0]             r1;
  logic [CIDX_W-1:0]             c0;
  logic [CIDX_W-1:0]             c1;
  logic [ACT_W-1:0]              pix;

  logic              out_valid_q;
  logic [ACT_W-1:0]  out_data_q;
  logic [CHAN_W-1:0] out_chan_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;
  logic              out_last_q;
  logic              drop_err_q;

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PQ_IDLE;
    else     state <= state_next;
  end

  // Next state plus capture / load / last-handshake decode
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    capture      = 1'b0;
    final_hs     = 1'b0;
    load         = 1'b0;
    case (state)
      PQ_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          capture    = 1'b1;
          state_next = PQ_SCAN;
        end
      end
      PQ_SCAN: begin
        // Once the last pixel is loaded, loads stop until it is taken.
        if (out_valid_q && bus.out_ready && out_last_q) begin
          final_hs   = 1'b1;
          state_next = PQ_IDLE;
        end else if (!out_valid_q || bus.out_ready) begin
          load = 1'b1;
        end
      end
      default: state_next = PQ_IDLE;
    endcase
  end

  // Frame buffer capture
  // NOTE: the buffer has no reset; it is always fully rewritten before being read.
  always_ff @(posedge clk) begin
    if (capture) frame_buf <= bus.in_frame;
  end

  // Window addressing for the current pooled coordinate
  always_comb begin
    r0 = RIDX_W'({row_cnt, 1'b0});
    r1 = RIDX_W'({row_cnt, 1'b1});
    c0 = CIDX_W'({col_cnt, 1'b0});
    c1 = CIDX_W'({col_cnt, 1'b1});
  end

  pool_quant_unit #(
    .SHIFT(SHIFT)
  ) u_unit (
    .p00(frame_buf[r0][c0]),
    .p01(frame_buf[r0][c1]),
    .p10(frame_buf[r1][c0]),
    .p11(frame_buf[r1][c1]),
    .q  (pix)
  );

  // Scan counters, output register and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q      <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      if (capture) begin
        chan_q  <= bus.in_chan;
        row_cnt <= '0;
        col_cnt <= '0;
      end
      if (final_hs) out_valid_q <= 1'b0;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pix;
        out_chan_q  <= chan_q;
        out_row_q   <= row_cnt;
        out_col_q   <= col_cnt;
        out_last_q  <= (row_cnt == ROW_W'(OUT_H - 1)) && (col_cnt == COL_W'(OUT_W - 1));
        if (col_cnt == COL_W'(OUT_W - 1)) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (state == PQ_SCAN && bus.in_valid) drop_err_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;
  assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_pool_quant.sv
// Self-checking bench for pool_quant: window table, throughput, stalls,
// dropped frames and mid-frame reset, with a scoreboard on pixel handshakes.
module tb_pool_quant;
  import npu_pkg::*;

  localparam int IN_H  = 12;
  localparam int IN_W  = 11;
  localparam int SHIFT = 8;
  localparam int OUT_H = IN_H / 2;
  localparam int OUT_W = IN_W / 2;
  localparam int NPIX  = OUT_H * OUT_W;
`ifdef POOL_QUANT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef logic signed [CONV_DATA_W-1:0] frame_t [IN_H][IN_W];

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] chan;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
  } pix_t;

  typedef struct {
    int a, b, c, d;
    int exp_trunc;
    int exp_round;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_count = 0;
  int   ready_mode = 0;
  pix_t exp_q[$];

  pool_quant_if #(.IN_H(IN_H), .IN_W(IN_W)) bus ();

  pool_quant #(.IN_H(IN_H), .IN_W(IN_W), .SHIFT(SHIFT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pix(input frame_t f, input int r, input int c);
    longint m;
    m = longint'(f[2*r][2*c]);
    if (longint'(f[2*r][2*c+1])   > m) m = longint'(f[2*r][2*c+1]);
    if (longint'(f[2*r+1][2*c])   > m) m = longint'(f[2*r+1][2*c]);
    if (longint'(f[2*r+1][2*c+1]) > m) m = longint'(f[2*r+1][2*c+1]);
    if (m < 0) m = 0;
    if (ROUND) m = m + (longint'(1) << (SHIFT - 1));
    m = m >> SHIFT;
    return (m > 255) ? 8'hFF : 8'(m);
  endfunction

  task automatic push_model(input frame_t f, input logic [3:0] ch);
    for (int r = 0; r < OUT_H; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        pix_t p;
        p.data = ref_pix(f, r, c);
        p.chan = ch;
        p.row  = 3'(r);
        p.col  = 3'(c);
        p.last = (r == OUT_H - 1) && (c == OUT_W - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic rand_frame(output frame_t f);
    for (int r = 0; r < IN_H; r++) begin
      for (int c = 0; c < IN_W; c++) begin
        int v;
        v = int'($urandom_range(0, 131071)) - 32768;
        if ($urandom_range(0, 15) == 0) v = int'($urandom()) >>> 8;
        f[r][c] = CONV_DATA_W'(v);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the capture edge.
  task automatic send_frame(input frame_t f, input logic [3:0] ch);
    int guard = 0;
    while (!bus.in_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_frame = f;
    bus.in_chan  = ch;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_hs(input int target);
    int guard = 0;
    while (hs_count < target && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_pixel", 32'(hs_count), 32'(target));
  endtask

  // Downstream ready: held high, or 1,0,0,1 followed by random
  initial begin
    int k = 0;
    logic [3:0] pat = 4'b1001;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) begin
        bus.out_ready = 1'b1;
        k = 0;
      end else begin
        bus.out_ready = (k < 4) ? pat[3-k] : 1'($urandom_range(0, 1));
        k++;
      end
    end
  end

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin : monitor
    pix_t cur;
    pix_t held;
    pix_t exp;
    bit   stalled;
    cur = '{data: bus.out_data, chan: bus.out_chan, row: bus.out_row,
            col: bus.out_col, last: bus.out_last};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {12'd0, bus.out_valid, cur}, {12'd0, 1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spare_pixel", 32'(cur), 32'(exp_q.size()));
        end else begin
          exp = exp_q.pop_front();
          check("pixel", 32'(cur), 32'(exp));
        end
        hs_count++;
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        held    = cur;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[12];
    frame_t f;
    frame_t g;
    int     run;

    vecs[0]  = '{256, 256, 256, 256, 1, 1};
    vecs[1]  = '{-5, 300, 1000, -70000, 3, 4};
    vecs[2]  = '{-1, -2, -3, -4, 0, 0};
    vecs[3]  = '{0, 0, 0, 8388607, 255, 255};
    vecs[4]  = '{0, 255, 0, 0, 0, 1};
    vecs[5]  = '{65535, -1, 0, 0, 255, 255};
    vecs[6]  = '{-512, 511, 0, 0, 1, 2};
    vecs[7]  = '{0, 0, 767, 0, 2, 3};
    vecs[8]  = '{127, 0, 0, -8388608, 0, 0};
    vecs[9]  = '{-8388608, -8388608, -8388608, -8388608, 0, 0};
    vecs[10] = '{0, 0, 0, 65280, 255, 255};
    vecs[11] = '{128, 0, 0, 0, 0, 1};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_chan  = '0;
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++) bus.in_frame[r][c] = '0;

    // Reset state
    #12;
    check("reset_state",
          {12'd0, bus.in_ready, bus.out_valid, bus.out_data, bus.out_chan,
           bus.out_row, bus.out_col, bus.out_last, bus.drop_err},
          {12'd0, 1'b1, 1'b0, 8'd0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Uniform 0x000100 frame at full rate: 30 back-to-back pixels of value 1
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++) f[r][c] = 24'sh000100;
    for (int i = 0; i < NPIX; i++) begin
      pix_t p;
      p.data = 8'd1;
      p.chan = 4'd5;
      p.row  = 3'(i / OUT_W);
      p.col  = 3'(i % OUT_W);
      p.last = (i == NPIX - 1);
      exp_q.push_back(p);
    end
    send_frame(f, 4'd5);
    check("busy_after_capture", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    check("first_valid_latency", 32'(bus.out_valid), 32'd1);
    run = 0;
    while (bus.out_valid && run < 100) begin
      run++;
      @(posedge clk); #1;
    end
    check("burst_len", 32'(run), 32'(NPIX));
    wait_drain("drain_uniform");

    // Window table: one window per frame, everything else zero except
    // full-scale values in the discarded column 10
    for (int i = 0; i < 12; i++) begin
      int pr, pc;
      pr = i % OUT_H;
      pc = (2 * i + 1) % OUT_W;
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++)
          f[r][c] = (c == IN_W - 1) ? 24'sh7FFFFF : 24'sh0;
      f[2*pr][2*pc]     = CONV_DATA_W'(vecs[i].a);
      f[2*pr][2*pc+1]   = CONV_DATA_W'(vecs[i].b);
      f[2*pr+1][2*pc]   = CONV_DATA_W'(vecs[i].c);
      f[2*pr+1][2*pc+1] = CONV_DATA_W'(vecs[i].d);
      for (int r = 0; r < OUT_H; r++) begin
        for (int c = 0; c < OUT_W; c++) begin
          pix_t p;
          p.data = (r == pr && c == pc) ? 8'(ROUND ? vecs[i].exp_round : vecs[i].exp_trunc) : 8'd0;
          p.chan = 4'(i);
          p.row  = 3'(r);
          p.col  = 3'(c);
          p.last = (r == OUT_H - 1) && (c == OUT_W - 1);
          exp_q.push_back(p);
        end
      end
      send_frame(f, 4'(i));
      wait_drain("drain_table");
    end

    // Random frames under a stalling consumer
    ready_mode = 1;
    for (int n = 0; n < 3; n++) begin
      rand_frame(f);
      push_model(f, 4'(9 + n));
      send_frame(f, 4'(9 + n));
      wait_drain("drain_stall");
    end
    ready_mode = 0;
    @(posedge clk); #1;

    // Frame offered while busy is dropped and flagged; current frame unaffected
    check("drop_err_clear", 32'(bus.drop_err), 32'd0);
    rand_frame(f);
    push_model(f, 4'd3);
    send_frame(f, 4'd3);
    wait_hs(hs_count + 7);
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    rand_frame(g);
    bus.in_frame = g;
    bus.in_chan  = 4'd12;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("drop_err_set", 32'(bus.drop_err), 32'd1);
    wait_drain("drain_drop");
    check("drop_err_sticky", 32'(bus.drop_err), 32'd1);

    // Reset in the middle of a frame
    rand_frame(f);
    push_model(f, 4'd7);
    send_frame(f, 4'd7);
    wait_hs(hs_count + 12);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("reset_mid_scan",
          {12'd0, bus.in_ready, bus.out_valid, bus.out_data, bus.out_chan,
           bus.out_row, bus.out_col, bus.out_last, bus.drop_err},
          {12'd0, 1'b1, 1'b0, 8'd0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    rand_frame(f);
    push_model(f, 4'd14);
    send_frame(f, 4'd14);
    wait_drain("drain_after_reset");
    check("drop_err_after_reset", 32'(bus.drop_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
